uart_fifo_wb: RTL and testbench

Wishbone-slave UART, next generation of the single-byte console UART. Adds parametrised RX/TX FIFOs, a runtime-writable baud divisor, sticky overrun/framing error flags and an optional interrupt. Sits on the 16-bit peripheral Wishbone bus beside the existing console UART, with its own serializer and deserializer.

---
 rtl/uart_fifo_wb.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_wb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_wb.sv
// Wishbone-slave UART with RX/TX FIFOs, runtime baud divisor and sticky error flags.
// Define UART_FIFO_WB_IRQ_EN to add the IRQEN register and the irq_o output.

module uart_fifo_wb_fifo #(
    parameter int AW = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 2 ** AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept then.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module uart_fifo_wb #(
    parameter int DIV_RESET   = 434,
    parameter int FIFO_AW     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        rx_i,
    output logic        tx_o
`ifdef UART_FIFO_WB_IRQ_EN
   ,output logic        irq_o
`endif
);
    localparam logic [3:0] ADR_STATUS = 4'h0;
    localparam logic [3:0] ADR_RXDATA = 4'h4;
    localparam logic [3:0] ADR_TXDATA = 4'h6;
    localparam logic [3:0] ADR_DIV    = 4'h8;
    localparam logic [3:0] ADR_IRQEN  = 4'hA;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic        unused_bits;
    assign unused_bits = ^{wb_adr_i[31:4], wb_sel_i};

    logic [3:0]  adr;
    logic        access;
    logic        rd_access;
    logic        wr_access;
    logic        status_clr;
    logic [15:0] rd_data;
    logic [15:0] div;
    logic        overrun;
    logic        framing_err;

    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_head;
    logic        tx_empty;
    logic        tx_full;
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_idle;

    logic        rx_pop;
    logic        rx_push;
    logic [7:0]  rx_head;
    logic        rx_empty;
    logic        rx_full;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic        rx_s;
    logic        rx_prev;
    logic [2:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_frame_err;

    logic        overrun_set;
    logic        framing_set;

`ifdef UART_FIFO_WB_IRQ_EN
    logic [2:0]  irq_en;
`endif

    assign adr        = wb_adr_i[3:0];
    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_access  = access & ~wb_we_i;
    assign wr_access  = access & wb_we_i;
    assign status_clr = rd_access && (adr == ADR_STATUS);
    assign rx_pop     = rd_access && (adr == ADR_RXDATA);
    assign tx_push    = wr_access && (adr == ADR_TXDATA);
    assign tx_idle    = tx_empty && (tx_state == TX_IDLE);

    uart_fifo_wb_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (tx_push),
        .din   (wb_dat_i[7:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    uart_fifo_wb_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_data = '0;
        if (rd_access) begin
            case (adr)
                ADR_STATUS: rd_data = {11'b0, tx_idle, framing_err, overrun, ~tx_full, ~rx_empty};
                ADR_RXDATA: rd_data = rx_empty ? 16'h0000 : {8'b0, rx_head};
                ADR_DIV:    rd_data = div;
`ifdef UART_FIFO_WB_IRQ_EN
                ADR_IRQEN:  rd_data = {13'b0, irq_en};
`endif
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            div      <= 16'(DIV_RESET);
        end else begin
            wb_ack_o <= access;
            if (rd_access) wb_dat_o <= rd_data;
            if (wr_access && (adr == ADR_DIV)) div <= (wb_dat_i < 16'd4) ? 16'd4 : wb_dat_i;
        end
    end

    // Error flags are sticky until a STATUS read; a new event in the same cycle wins.
    assign overrun_set = (tx_push & tx_full & ~tx_pop) | (rx_push & rx_full & ~rx_pop);
    assign framing_set = rx_frame_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            overrun     <= overrun_set | (overrun & ~status_clr);
            framing_err <= framing_set | (framing_err & ~status_clr);
        end
    end

    // The next byte is taken in IDLE or at the end of STOP, which keeps frames back-to-back.
    assign tx_pop = ~tx_empty && ((tx_state == TX_IDLE) ||
                                  ((tx_state == TX_STOP) && (tx_cnt == 16'd0)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_o     <= 1'b0;
                        tx_cnt   <= div - 16'd1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_o     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= '0;
                        tx_cnt   <= div - 16'd1;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div - 16'd1;
                        if (tx_idx == 3'd7) begin
                            tx_o     <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_o     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            tx_o     <= 1'b0;
                            tx_cnt   <= div - 16'd1;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    tx_o     <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign rx_s         = rx_sync[SYNC_STAGES-1];
    assign rx_push      = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && rx_s;
    assign rx_frame_err = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && ~rx_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync  <= '1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_i};
            rx_prev <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt   <= (div >> 1) - 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        rx_cnt   <= div - 16'd1;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= div - 16'd1;
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) rx_state <= rx_s ? RX_IDLE : RX_WAIT;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
                RX_WAIT: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_FIFO_WB_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en <= '0;
            irq_o  <= 1'b0;
        end else begin
            if (wr_access && (adr == ADR_IRQEN)) irq_en <= wb_dat_i[2:0];
            irq_o <= (irq_en[0] & ~rx_empty) |
                     (irq_en[1] & tx_idle) |
                     (irq_en[2] & (overrun | framing_err));
        end
    end
`endif
endmodule

// File: tb/tb_uart_fifo_wb.sv
// Directed self-checking bench for uart_fifo_wb (optional IRQ checks follow UART_FIFO_WB_IRQ_EN).

module tb_uart_fifo_wb;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i = 2'b11;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic        rx_i = 1'b1;
    logic        tx_o;
`ifdef UART_FIFO_WB_IRQ_EN
    logic        irq_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    uart_fifo_wb #(.DIV_RESET(434), .FIFO_AW(4), .SYNC_STAGES(2)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o),
        .rx_i    (rx_i),
        .tx_o    (tx_o)
`ifdef UART_FIFO_WB_IRQ_EN
       ,.irq_o   (irq_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                           output logic [15:0] rdat);
        bit acked = 0;
        @(negedge clk_i);
        wb_adr_i = {28'b0, adr};
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            if (wb_ack_o) begin
                acked = 1;
                break;
            end
        end
        if (!acked) check("ack_timeout", 0, 1);
        rdat = wb_dat_o;
        @(negedge clk_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [15:0] dat);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, dat, dummy);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [15:0] rdat);
        wb_xfer(1'b0, adr, 16'h0000, rdat);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (div) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (div) @(negedge clk_i);
        end
        rx_i = stop;
        repeat (div) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (2 * div) @(negedge clk_i);
    endtask

    logic [15:0] rd;
    bit          found;
    logic        tx_seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk_i);
        check("reset_tx_o", tx_o, 1);
        check("reset_ack", wb_ack_o, 0);
        check("reset_dat_o", wb_dat_o, 16'h0000);
        rst_ni = 1'b1;
        wb_read(4'h0, rd);
        check("reset_status", rd, 16'h0012);
        @(posedge clk_i); #1;
        check("ack_single_cycle", wb_ack_o, 0);
        wb_read(4'h8, rd);
        check("reset_div", rd, 16'd434);

        // Reset asserted in the middle of a frame
        wb_write(4'h6, 16'h00A5);
        repeat (20) @(negedge clk_i);
        check("midframe_start_bit", tx_o, 0);
        #2 rst_ni = 1'b0;
        #1 check("midframe_async_tx", tx_o, 1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        wb_read(4'h0, rd);
        check("midframe_status", rd, 16'h0012);
        wb_read(4'h8, rd);
        check("midframe_div", rd, 16'd434);

        // Divisor clamp, then fast divisor
        wb_write(4'h8, 16'd2);
        wb_read(4'h8, rd);
        check("div_clamp", rd, 16'd4);
        wb_write(4'h8, 16'd4);

        // TX of 0xA5
        wb_write(4'h6, 16'h00A5);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (tx_o == 1'b0) begin
                found = 1;
                break;
            end
        end
        check("tx_start_found", found, 1);
        repeat (2) @(negedge clk_i);
        check("tx_bit0", tx_o, tx_seq[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clk_i);
            check($sformatf("tx_bit%0d", k), tx_o, tx_seq[k]);
        end
        repeat (4) @(negedge clk_i);
        wb_read(4'h0, rd);
        check("tx_idle_after", rd, 16'h0012);

        // RX of 0x3C
        send_rx(8'h3C, 1'b1, 4);
        wb_read(4'h0, rd);
        check("rx_status_ready", rd, 16'h0013);
        wb_read(4'h4, rd);
        check("rx_data_3c", rd, 16'h003C);
        wb_read(4'h0, rd);
        check("rx_status_empty", rd, 16'h0012);
        wb_read(4'h4, rd);
        check("rx_read_empty", rd, 16'h0000);

        // 17 bytes with no reads: 17th overruns
        for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1, 4);
        for (int i = 0; i < 16; i++) begin
            wb_read(4'h4, rd);
            check($sformatf("ovr_data%0d", i), rd, 16'(8'h40 + i));
        end
        wb_read(4'h0, rd);
        check("ovr_status", rd, 16'h0016);
        wb_read(4'h0, rd);
        check("ovr_cleared", rd, 16'h0012);

        // Framing error, then a good byte
        send_rx(8'h00, 1'b0, 4);
        send_rx(8'h55, 1'b1, 4);
        wb_read(4'h0, rd);
        check("frm_status", rd, 16'h001B);
        wb_read(4'h4, rd);
        check("frm_data55", rd, 16'h0055);
        wb_read(4'h4, rd);
        check("frm_only_entry", rd, 16'h0000);
        wb_read(4'h0, rd);
        check("frm_cleared", rd, 16'h0012);

        // Two-cycle glitch on idle line
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (60) @(negedge clk_i);
        wb_read(4'h0, rd);
        check("glitch_status", rd, 16'h0012);

        // Unmapped and write-only addresses
        wb_read(4'hC, rd);
        check("unmapped_read", rd, 16'h0000);
        wb_read(4'h6, rd);
        check("txdata_read", rd, 16'h0000);

`ifdef UART_FIFO_WB_IRQ_EN
        wb_write(4'hA, 16'h0001);
        wb_read(4'hA, rd);
        check("irqen_read", rd, 16'h0001);
        check("irq_idle", irq_o, 0);
        send_rx(8'h01, 1'b1, 4);
        check("irq_rx", irq_o, 1);
        wb_read(4'h4, rd);
        check("irq_rx_data", rd, 16'h0001);
        @(posedge clk_i); #1;
        check("irq_cleared", irq_o, 0);
`else
        wb_write(4'hA, 16'h0007);
        wb_read(4'hA, rd);
        check("irqen_absent", rd, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
